// File: rtl/ads1115_scan_sched.sv
// ADS1115 scan scheduler: for each enabled channel, writes the config register, polls the OS bit,
// reads the conversion result, and starts a new scan every SAMPLE_PERIOD cycles.
module ads1115_scan_sched #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned SAMPLE_PERIOD = 5_000_000,
    parameter logic [6:0]  DEV_ADDR      = 7'h48,
    parameter logic [2:0]  PGA           = 3'b001,
    parameter logic [2:0]  DR            = 3'b100,
    parameter logic [3:0]  CH_MASK       = 4'b1111,
    parameter int unsigned POLL_GAP      = 5000,
    parameter int unsigned MAX_POLLS     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        i2c_start,
    output logic        i2c_rw,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_ptr,
    output logic [15:0] i2c_wdata,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [15:0] i2c_rdata,
    output logic [15:0] sample_data,
    output logic [1:0]  sample_ch,
    output logic        sample_valid,
    output logic        err_nack,
    output logic        err_timeout,
    output logic        scan_busy
);
    localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned PW = $clog2(MAX_POLLS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST   = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);

    if (SAMPLE_PERIOD < 2 || CLK_FREQ == 0 || MAX_POLLS == 0) begin : g_bad_params
        $error("ads1115_scan_sched: invalid parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_PERIOD, S_CFG_REQ, S_CFG_WAIT, S_POLL_GAP,
        S_POLL_REQ, S_POLL_WAIT, S_READ_REQ, S_READ_WAIT, S_NEXT_CH
    } state_t;

    state_t          state, state_n;
    logic [1:0]      ch, ch_n;
    logic [TW-1:0]   timer, timer_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic [PW-1:0]   poll_cnt, poll_n, poll_inc;
    logic            start_n, rw_n, valid_n, enack_n, etmo_n, busy_n;
    logic [7:0]      ptr_n;
    logic [15:0]     wdata_n, sdata_n, cfg_word;
    logic [1:0]      sch_n;
    logic [2:0]      first_sel, next_sel;

    // Returns {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [2:0] find_ch(input logic [2:0] from);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r[2] && CH_MASK[i] && i >= 32'(from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_sel = find_ch(3'd0);
    assign next_sel  = find_ch({1'b0, ch} + 3'd1);
    assign cfg_word  = {1'b1, 1'b1, ch, PGA, 1'b1, DR, 5'b00011};
    assign poll_inc  = poll_cnt + PW'(1);
    assign i2c_addr  = DEV_ADDR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ch           <= '0;
            timer        <= '0;
            gap_cnt      <= '0;
            poll_cnt     <= '0;
            i2c_start    <= 1'b0;
            i2c_rw       <= 1'b0;
            i2c_ptr      <= '0;
            i2c_wdata    <= '0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            err_nack     <= 1'b0;
            err_timeout  <= 1'b0;
            scan_busy    <= 1'b0;
        end else begin
            state        <= state_n;
            ch           <= ch_n;
            timer        <= timer_n;
            gap_cnt      <= gap_n;
            poll_cnt     <= poll_n;
            i2c_start    <= start_n;
            i2c_rw       <= rw_n;
            i2c_ptr      <= ptr_n;
            i2c_wdata    <= wdata_n;
            sample_data  <= sdata_n;
            sample_ch    <= sch_n;
            sample_valid <= valid_n;
            err_nack     <= enack_n;
            err_timeout  <= etmo_n;
            scan_busy    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        ch_n    = ch;
        gap_n   = gap_cnt;
        poll_n  = poll_cnt;
        // The period timer saturates so an overrunning scan is detected without wrap-around.
        timer_n = (timer == TIMER_LAST) ? timer : timer + TW'(1);
        start_n = 1'b0;
        rw_n    = i2c_rw;
        ptr_n   = i2c_ptr;
        wdata_n = i2c_wdata;
        sdata_n = sample_data;
        sch_n   = sample_ch;
        valid_n = 1'b0;
        enack_n = 1'b0;
        etmo_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && first_sel[2]) begin
                    ch_n    = first_sel[1:0];
                    timer_n = '0;
                    state_n = S_CFG_REQ;
                end
            end
            S_WAIT_PERIOD: begin
                if (!enable) state_n = S_IDLE;
                else if (timer == TIMER_LAST) begin
                    ch_n    = first_sel[1:0];
                    timer_n = '0;
                    state_n = S_CFG_REQ;
                end
            end
            S_CFG_REQ: begin
                if (!i2c_busy) begin
                    start_n = 1'b1;
                    rw_n    = 1'b0;
                    ptr_n   = 8'h01;
                    wdata_n = cfg_word;
                    state_n = S_CFG_WAIT;
                end
            end
            S_CFG_WAIT: begin
                if (i2c_done) begin
                    if (i2c_nack) begin
                        enack_n = 1'b1;
                        state_n = S_NEXT_CH;
                    end else begin
                        poll_n  = '0;
                        gap_n   = '0;
                        state_n = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                if (!enable) state_n = S_IDLE;
                else if (gap_cnt == GAP_LAST) state_n = S_POLL_REQ;
                else gap_n = gap_cnt + GW'(1);
            end
            S_POLL_REQ: begin
                if (!i2c_busy) begin
                    start_n = 1'b1;
                    rw_n    = 1'b1;
                    ptr_n   = 8'h01;
                    state_n = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (i2c_done) begin
                    if (i2c_nack) begin
                        enack_n = 1'b1;
                        state_n = S_NEXT_CH;
                    end else if (i2c_rdata[15]) begin
                        state_n = S_READ_REQ;
                    end else if (poll_inc == POLL_LIMIT) begin
                        etmo_n  = 1'b1;
                        state_n = S_NEXT_CH;
                    end else begin
                        poll_n  = poll_inc;
                        gap_n   = '0;
                        state_n = S_POLL_GAP;
                    end
                end
            end
            S_READ_REQ: begin
                if (!i2c_busy) begin
                    start_n = 1'b1;
                    rw_n    = 1'b1;
                    ptr_n   = 8'h00;
                    state_n = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (i2c_done) begin
                    if (i2c_nack) enack_n = 1'b1;
                    else begin
                        sdata_n = i2c_rdata;
                        sch_n   = ch;
                        valid_n = 1'b1;
                    end
                    state_n = S_NEXT_CH;
                end
            end
            S_NEXT_CH: begin
                if (!enable) state_n = S_IDLE;
                else if (next_sel[2]) begin
                    ch_n    = next_sel[1:0];
                    state_n = S_CFG_REQ;
                end else if (timer == TIMER_LAST) begin
                    ch_n    = first_sel[1:0];
                    timer_n = '0;
                    state_n = S_CFG_REQ;
                end else begin
                    state_n = S_WAIT_PERIOD;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = !(state_n inside {S_IDLE, S_WAIT_PERIOD});
    end
endmodule

// File: doc/ads1115_scan_sched.md
# ads1115_scan_sched

Transaction-level scheduler for the ADS1115 ADC. It sits between the board-level top and the byte-level I2C master engine. It sequences single-shot conversions over the enabled analog inputs (A0–A3) at a fixed sample period, and delivers each 16-bit result with its channel tag. It owns all ADS1115 register accesses: config write, OS-bit polling and conversion read. It reports NACK and conversion-timeout errors.

## Interface
- `CLK_FREQ`, 50_000_000: system clock in Hz; informational, used only to derive defaults.
- `SAMPLE_PERIOD`, 5_000_000: clock cycles between scan starts (≥ 2).
- `DEV_ADDR`, 7'h48: ADS1115 7-bit I2C address.
- `PGA`, 3'b001: full-scale range field, config bits [11:9].
- `DR`, 3'b100: data-rate field, config bits [7:5].
- `CH_MASK`, 4'b1111: bit n enables AINn (single-ended).
- `POLL_GAP`, 5000: idle cycles between OS-bit polls.
- `MAX_POLLS`, 64: polls before a conversion timeout.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; scanning runs while high.
- `i2c_start` out 1: one-cycle transaction request.
- `i2c_rw` out 1: 0 = register write (pointer + 16 bits); 1 = register read (pointer write, repeated start, 16-bit read).
- `i2c_addr` out 7: always `DEV_ADDR`.
- `i2c_ptr` out 8: ADS1115 pointer register value.
- `i2c_wdata` out 16: write data, MSB first.
- `i2c_busy` in 1: master engine busy.
- `i2c_done` in 1: one-cycle end-of-transaction pulse.
- `i2c_nack` in 1: valid with `i2c_done`; any NACK in the transaction.
- `i2c_rdata` in 16: read data, valid with `i2c_done`.
- `sample_data` out 16: last conversion result (two's complement).
- `sample_ch` out 2: channel of `sample_data`.
- `sample_valid` out 1: one-cycle pulse on new sample.
- `err_nack` out 1: one-cycle pulse; channel skipped because of a NACK.
- `err_timeout` out 1: one-cycle pulse; channel skipped because of an OS timeout.
- `scan_busy` out 1: high from scan start until the last channel completes.

## Operation
- States:
  - IDLE
  - WAIT_PERIOD
  - CFG_REQ, CFG_WAIT
  - POLL_GAP, POLL_REQ, POLL_WAIT
  - READ_REQ, READ_WAIT
  - NEXT_CH
- IDLE → CFG_REQ when `enable`=1 and `CH_MASK`≠0. The channel pointer loads the lowest set bit of `CH_MASK`, and the period timer clears.
- CFG_REQ issues a write with `i2c_ptr`=8'h01. The config word is {1'b1, 1'b1, ch[1:0], PGA, 1'b1, DR, 5'b00011}, i.e. OS=1, single-ended MUX=1xx, single-shot mode, comparator disabled. Example: ch1 with defaults gives 16'hD383.
- CFG_WAIT on `i2c_done`:
  - nack → `err_nack`, go to NEXT_CH.
  - otherwise → POLL_GAP, poll counter = 0.
- POLL_GAP waits `POLL_GAP` cycles, then goes to POLL_REQ.
- POLL_REQ issues a read with `i2c_ptr`=8'h01.
- POLL_WAIT on `i2c_done`:
  - nack → `err_nack`, go to NEXT_CH.
  - `i2c_rdata[15]`=1 → READ_REQ.
  - otherwise increment the poll counter. If the counter equals `MAX_POLLS`, pulse `err_timeout` and go to NEXT_CH; else go back to POLL_GAP.
- READ_REQ issues a read with `i2c_ptr`=8'h00.
- READ_WAIT on `i2c_done`:
  - nack → `err_nack`.
  - otherwise latch `sample_data`=`i2c_rdata` and `sample_ch`=ch, and pulse `sample_valid`.
  - Either way go to NEXT_CH.
- NEXT_CH advances to the next higher set bit of `CH_MASK`.
  - If one exists → CFG_REQ.
  - If none → `scan_busy` drops and the state goes to WAIT_PERIOD.
- WAIT_PERIOD → CFG_REQ (new scan) when the period timer reaches `SAMPLE_PERIOD`-1. The timer restarts at scan start.
  - A scan that overruns the period starts the next scan in the cycle after NEXT_CH.
  - No periods are queued.
- `enable` low is sampled only in NEXT_CH, WAIT_PERIOD and POLL_GAP, and returns the FSM to IDLE. An in-flight I2C transaction is never abandoned.
- Errors never halt scanning; a failed channel is retried in the next scan.

## Timing
- Reset (async): state IDLE, all outputs 0. `i2c_addr` is the constant `DEV_ADDR`. `sample_data`=0, `sample_ch`=0, timers and counters 0.
- `i2c_start` is a single-cycle pulse, asserted in a *_REQ state only when `i2c_busy`=0. Otherwise the FSM holds in *_REQ.
- `i2c_rw`, `i2c_ptr` and `i2c_wdata` are registered, set in the cycle `i2c_start` rises, and held stable until `i2c_done`.
- `i2c_done` arriving while not in a *_WAIT state is ignored.
- `sample_valid`, `err_nack` and `err_timeout` pulse in the cycle after `i2c_done` is sampled. They are mutually exclusive.
- `sample_data` and `sample_ch` hold until the next valid sample.
- IDLE → first `i2c_start`: 2 cycles after `enable` rises, given `i2c_busy`=0.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. The I2C master is reset by the same `rst`.

## Test plan
- Behavioural I2C slave model; `SAMPLE_PERIOD`=20000, `POLL_GAP`=10, `CH_MASK`=4'b0101, OS=1 on the second poll. Expected:
  - config words 16'hC383 (ch0) and 16'hE383 (ch2);
  - one `sample_valid` for ch0 (data 16'h1234) and one for ch2 (data 16'h8001);
  - `scan_busy` low afterwards.
- Second scan: first `i2c_start` exactly 20000 cycles after the first scan's first `i2c_start`.
- Slave NACKs the ch2 config write → one `err_nack`, no ch2 sample, scan still finishes; next scan samples ch2.
- OS never sets, `MAX_POLLS`=4 → exactly 4 polls, then `err_timeout`, then the next channel proceeds.
- `i2c_busy` held high for 50 cycles in CFG_REQ → no `i2c_start` until it drops; `enable` dropped mid-READ_WAIT → the read completes, the sample is delivered, then IDLE.
- `CH_MASK`=0 → no `i2c_start` ever. `rst` pulsed mid-POLL_WAIT → all outputs 0 the same cycle; restart with a fresh config write.
